// File: rtl/sat_search_ctrl.sv
// DPLL search sequencer for the bcp_top propagation unit.
// Keeps the working assignment/free vectors and issues propagation requests.
// Decides lowest-index free variable first, trying 1 before 0, and backtracks
// chronologically through a per-level decision stack.
module sat_search_ctrl #(
    parameter int var_num     = 4,
    parameter int var_num_log = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   initial_request,
    output logic                   bcp_request,
    output logic [var_num-1:0]     assignment,
    output logic [var_num-1:0]     free,
    input  logic                   bcp_done,
    input  logic                   bcp_conflict,
    input  logic [var_num-1:0]     imp_mask,
    input  logic [var_num-1:0]     imp_val,
    output logic                   busy,
    output logic                   done,
    output logic                   sat,
    output logic [var_num_log:0]   level,
    output logic [15:0]            req_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT, S_DECIDE, S_BACKTRACK, S_SAT, S_UNSAT
    } state_t;

    localparam logic [var_num_log:0] LVL_ONE = (var_num_log+1)'(1);

    state_t state;

    // Decision stack, one entry per level; entry i belongs to level i+1.
    logic [var_num-1:0]     stk_asg  [var_num];
    logic [var_num-1:0]     stk_free [var_num];
    logic [var_num_log-1:0] stk_var  [var_num];
    logic [var_num-1:0]     stk_flip;

    logic [var_num_log-1:0] dec_var;
    logic [var_num_log-1:0] push_idx;
    logic [var_num_log-1:0] top_idx;
    logic [var_num-1:0]     top_bit;

    // Lowest-index free variable is the next decision candidate.
    always_comb begin
        dec_var = '0;
        for (int i = var_num - 1; i >= 0; i--) begin
            if (free[i]) dec_var = var_num_log'(i);
        end
    end

    // Push slot is the current level; the top entry is level-1 (wraps harmlessly at level 0).
    assign push_idx = level[var_num_log-1:0];
    assign top_idx  = level[var_num_log-1:0] - var_num_log'(1);
    assign top_bit  = var_num'(1) << stk_var[top_idx];

    // Search state machine; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            assignment      <= '0;
            free            <= '1;
            level           <= '0;
            req_cnt         <= '0;
            initial_request <= 1'b0;
            bcp_request     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            sat             <= 1'b0;
        end else begin
            initial_request <= 1'b0;
            bcp_request     <= 1'b0;
            case (state)
                S_IDLE, S_SAT, S_UNSAT: begin
                    if (start) begin
                        assignment      <= '0;
                        free            <= '1;
                        level           <= '0;
                        req_cnt         <= '0;
                        sat             <= 1'b0;
                        done            <= 1'b0;
                        busy            <= 1'b1;
                        initial_request <= 1'b1;
                        state           <= S_INIT;
                    end
                end
                S_INIT: state <= S_WAIT;
                S_WAIT: begin
                    if (bcp_done) begin
                        if (bcp_conflict) begin
                            state <= S_BACKTRACK;
                        end else begin
                            free       <= free & ~imp_mask;
                            assignment <= (assignment & ~imp_mask) | (imp_val & imp_mask);
                            state      <= S_DECIDE;
                        end
                    end
                end
                S_DECIDE: begin
                    if (free == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sat   <= 1'b1;
                        state <= S_SAT;
                    end else begin
                        stk_asg[push_idx]    <= assignment;
                        stk_free[push_idx]   <= free;
                        stk_var[push_idx]    <= dec_var;
                        stk_flip[push_idx]   <= 1'b0;
                        assignment[dec_var]  <= 1'b1;
                        free[dec_var]        <= 1'b0;
                        level                <= level + LVL_ONE;
                        bcp_request          <= 1'b1;
                        if (req_cnt != 16'hFFFF) req_cnt <= req_cnt + 16'd1;
                        state                <= S_WAIT;
                    end
                end
                S_BACKTRACK: begin
                    if (level == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sat   <= 1'b0;
                        state <= S_UNSAT;
                    end else if (!stk_flip[top_idx]) begin
                        // Second branch: restore the pre-decision snapshot, try value 0.
                        assignment        <= stk_asg[top_idx] & ~top_bit;
                        free              <= stk_free[top_idx] & ~top_bit;
                        stk_flip[top_idx] <= 1'b1;
                        bcp_request       <= 1'b1;
                        if (req_cnt != 16'hFFFF) req_cnt <= req_cnt + 16'd1;
                        state             <= S_WAIT;
                    end else begin
                        // Both branches exhausted: pop one level per cycle.
                        level <= level - LVL_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sat_search_ctrl.sv
// Bench for sat_search_ctrl: a clause-driven bcp responder plus a reference
// model that derives the search outcome by enumerating assignments in DPLL order.
module tb_sat_search_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        initial_request, bcp_request;
    logic [3:0]  assignment, free;
    logic        bcp_done, bcp_conflict;
    logic [3:0]  imp_mask, imp_val;
    logic        busy, done, sat;
    logic [2:0]  level;
    logic [15:0] req_cnt;

    sat_search_ctrl #(.var_num(4), .var_num_log(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .initial_request(initial_request), .bcp_request(bcp_request),
        .assignment(assignment), .free(free),
        .bcp_done(bcp_done), .bcp_conflict(bcp_conflict),
        .imp_mask(imp_mask), .imp_val(imp_val),
        .busy(busy), .done(done), .sat(sat),
        .level(level), .req_cnt(req_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Problem instance seen by the responder and the model.
    logic [3:0] cl_p [8];
    logic [3:0] cl_n [8];
    int         num_cl = 0;
    logic       root_conf = 1'b0;
    logic [3:0] imp_m = '0, imp_v = '0;
    int         spur_cnt = 0;

    // A clause is falsified when all its literals are assigned and false.
    function automatic logic falsified(input logic [3:0] a, input logic [3:0] f);
        for (int c = 0; c < num_cl; c++) begin
            if ((((cl_p[c] | cl_n[c]) & f) == 4'b0) && ((cl_p[c] & a) == 4'b0) &&
                ((cl_n[c] & ~a) == 4'b0))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Pulse monitor.
    int n_init = 0, n_req = 0;
    always @(negedge clk) begin
        if (initial_request) n_init++;
        if (bcp_request) n_req++;
        if (initial_request && bcp_request) chk("req_exclusive", 1, 0);
    end

    // bcp_top stand-in: answers each request after a random delay.
    initial begin
        int         spur_seen;
        int         dly;
        logic       c;
        logic [3:0] m, v;
        spur_seen    = 0;
        bcp_done     = 1'b0;
        bcp_conflict = 1'b0;
        imp_mask     = '0;
        imp_val      = '0;
        forever begin
            @(negedge clk);
            bcp_done = 1'b0;
            if (spur_cnt != spur_seen) begin
                spur_seen    = spur_cnt;
                bcp_done     = 1'b1;
                bcp_conflict = 1'b0;
                imp_mask     = 4'hF;
                imp_val      = 4'hF;
            end else if (initial_request || bcp_request) begin
                if (initial_request) begin
                    dly = $urandom_range(1, 3);
                    c   = root_conf;
                    m   = c ? 4'($urandom) : imp_m;
                    v   = c ? 4'($urandom) : imp_v;
                end else begin
                    dly = $urandom_range(0, 2);
                    c   = falsified(assignment, free);
                    m   = c ? 4'($urandom) : 4'b0;
                    v   = 4'($urandom);
                end
                repeat (dly) @(negedge clk);
                bcp_done     = 1'b1;
                bcp_conflict = c;
                imp_mask     = m;
                imp_val      = v;
            end
        end
    end

    // Reference model state: decision order and post-initial-pass base.
    int         dvars [4];
    int         nd;
    logic [3:0] a0, f0;

    // Apply the first k decisions encoded in key (MSB = first decision, 0 means value 1).
    task automatic build(input int key, input int k, output logic [3:0] a, output logic [3:0] f);
        a = a0;
        f = f0;
        for (int j = 0; j < k; j++) begin
            a[dvars[j]] = ~key[k-1-j];
            f[dvars[j]] = 1'b0;
        end
    endtask

    task automatic model(output logic e_sat, output logic [3:0] e_asg, output logic [3:0] e_free,
                         output int e_lvl, output int e_req);
        logic [3:0] a, f;
        int         s;
        logic       found, ok;
        a0 = imp_v & imp_m;
        f0 = ~imp_m;
        nd = 0;
        for (int i = 0; i < 4; i++) if (f0[i]) begin dvars[nd] = i; nd++; end
        e_sat = 1'b0; e_asg = 4'b0; e_free = 4'hF; e_lvl = 0; e_req = 0;
        if (root_conf) return;
        found = 1'b0;
        s     = 0;
        if (nd == 0) found = 1'b1;
        else begin
            for (int key = 0; key < (1 << nd) && !found; key++) begin
                build(key, nd, a, f);
                if (!falsified(a, f)) begin found = 1'b1; s = key; end
            end
        end
        // A node is visited if its parent passed propagation and it precedes or lies on the solution path.
        for (int k = 1; k <= nd; k++) begin
            for (int p = 0; p < (1 << k); p++) begin
                ok = 1'b1;
                if (k > 1) begin
                    build(p >> 1, k - 1, a, f);
                    ok = !falsified(a, f);
                end
                if (ok && (!found || p <= (s >> (nd - k)))) e_req++;
            end
        end
        e_sat = found;
        e_lvl = found ? nd : 0;
        if (found) build(s, nd, e_asg, e_free);
    endtask

    task automatic run_search(input string name, input logic poke);
        logic       e_sat;
        logic [3:0] e_asg, e_free;
        int         e_lvl, e_req, b_init, b_req, cyc;
        model(e_sat, e_asg, e_free, e_lvl, e_req);
        b_init = n_init;
        b_req  = n_req;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        if (poke) begin
            @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        end
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            chk({name, "_timeout"}, 0, 1);
            return;
        end
        repeat (6) @(negedge clk);
        chk({name, "_done"}, done, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_sat"}, sat, e_sat);
        chk({name, "_level"}, level, e_lvl);
        chk({name, "_req_cnt"}, req_cnt, e_req);
        chk({name, "_req_pulses"}, n_req - b_req, e_req);
        chk({name, "_init_pulses"}, n_init - b_init, 1);
        if (e_sat || root_conf) begin
            chk({name, "_assignment"}, assignment, e_asg);
            chk({name, "_free"}, free, e_free);
        end
    endtask

    task automatic clear_inst();
        num_cl = 0; root_conf = 1'b0; imp_m = 4'b0; imp_v = 4'b0;
    endtask

    initial begin
        int b, cyc;
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat, 0);
        chk("rst_assignment", assignment, 4'b0000);
        chk("rst_free", free, 4'b1111);
        chk("rst_level", level, 0);
        chk("rst_req_cnt", req_cnt, 0);
        repeat (20) @(negedge clk);
        chk("idle_no_pulses", n_init + n_req, 0);
        spur_cnt++;
        repeat (3) @(negedge clk);
        chk("spur_free", free, 4'b1111);
        chk("spur_assignment", assignment, 4'b0000);
        chk("spur_busy", busy, 0);

        clear_inst();
        run_search("all_ones", 1'b0);

        clear_inst();
        imp_m = 4'b0110; imp_v = 4'b0100;
        run_search("implied", 1'b0);

        clear_inst();
        root_conf = 1'b1;
        run_search("root_conflict", 1'b0);

        clear_inst();
        num_cl = 1; cl_p[0] = 4'b0000; cl_n[0] = 4'b0001;
        run_search("flip_x0", 1'b0);

        clear_inst();
        num_cl = 2; cl_p[0] = 4'b0001; cl_n[0] = 4'b0000; cl_p[1] = 4'b0000; cl_n[1] = 4'b0001;
        run_search("unsat_x0", 1'b1);

        for (int t = 0; t < 40; t++) begin
            num_cl = $urandom_range(0, 4);
            for (int c = 0; c < num_cl; c++) begin
                do begin
                    cl_p[c] = 4'($urandom);
                    cl_n[c] = 4'($urandom) & ~cl_p[c];
                end while ((cl_p[c] | cl_n[c]) == 4'b0);
            end
            root_conf = ($urandom_range(0, 7) == 0);
            imp_m     = 4'($urandom & $urandom);
            imp_v     = 4'($urandom);
            run_search($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
        end

        // Reset while waiting on a propagation request.
        clear_inst();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!bcp_request && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_wait_reached", bcp_request, 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sat", sat, 0);
        chk("mid_rst_assignment", assignment, 4'b0000);
        chk("mid_rst_free", free, 4'b1111);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_req_cnt", req_cnt, 0);
        chk("mid_rst_bcp_req", bcp_request, 0);
        b = n_init + n_req;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_pulses", n_init + n_req - b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
